// File: rtl/pw_multi_pattern_matcher_pkg.sv
// Shared definitions for the multi-pattern matcher.
// Holds the per-channel action codes, the per-channel state encoding,
// common field widths and a helper that decides whether a programmed
// pattern length is usable.
package pw_multi_pattern_matcher_pkg;

  // Field widths shared by the interface, the top level and the channels
  localparam int PM_BYTE_W     = 8;
  localparam int PM_LEN_W      = 8;
  localparam int PM_ACTION_W   = 2;
  localparam int PM_CHAN_IDX_W = 3;

  // What a channel asks for when it matches
  typedef enum logic [PM_ACTION_W-1:0] {
    PM_NOP     = 2'd0,
    PM_CAPTURE = 2'd1,
    PM_TRIGGER = 2'd2
  } pm_action_e;

  // Per-channel matching state
  typedef enum logic [1:0] {
    PM_IDLE  = 2'd0,
    PM_ARMED = 2'd1,
    PM_FIRED = 2'd2
  } pm_state_e;

  // A length of zero, or one longer than the window, switches the channel off
  function automatic logic lenEnabled(input logic [PM_LEN_W-1:0] len, input int maxBytes);
    return (len != '0) && (int'(len) <= maxBytes);
  endfunction

endpackage

// File: rtl/pw_multi_pattern_matcher_if.sv
// Configuration, data and result bundle of the multi-pattern matcher.
// master : the side that programs patterns and feeds bytes (drives I_*)
// slave  : the matcher itself (drives O_*)
// Packed per-channel fields place channel n at slice n of the vector;
// inside a pattern/mask, byte 0 is the most recently received byte.
interface pw_multi_pattern_matcher_if
  import pw_multi_pattern_matcher_pkg::*;
#(
  parameter int pCHANNELS      = 2,
  parameter int pPATTERN_BYTES = 8,
  parameter int pCOUNT_WIDTH   = 16
) ();

  logic                                          I_arm;
  logic                                          I_oneshot;
  logic [pCHANNELS*pPATTERN_BYTES*PM_BYTE_W-1:0] I_pattern;
  logic [pCHANNELS*pPATTERN_BYTES*PM_BYTE_W-1:0] I_mask;
  logic [pCHANNELS*PM_LEN_W-1:0]                 I_pattern_bytes;
  logic [pCHANNELS*PM_ACTION_W-1:0]              I_action;
  logic [PM_BYTE_W-1:0]                          I_fe_data;
  logic                                          I_fe_data_valid;
  logic                                          I_capturing;
  logic [pCHANNELS-1:0]                          O_match;
  logic [pCHANNELS-1:0]                          O_match_pulse;
  logic [PM_CHAN_IDX_W-1:0]                      O_match_channel;
  logic                                          O_match_capture;
  logic                                          O_match_trigger;
  logic [pCHANNELS*pCOUNT_WIDTH-1:0]             O_hit_count;

  modport master (
    output I_arm, I_oneshot, I_pattern, I_mask, I_pattern_bytes, I_action,
           I_fe_data, I_fe_data_valid, I_capturing,
    input  O_match, O_match_pulse, O_match_channel, O_match_capture,
           O_match_trigger, O_hit_count
  );

  modport slave (
    input  I_arm, I_oneshot, I_pattern, I_mask, I_pattern_bytes, I_action,
           I_fe_data, I_fe_data_valid, I_capturing,
    output O_match, O_match_pulse, O_match_channel, O_match_capture,
           O_match_trigger, O_hit_count
  );

endinterface

// File: rtl/pw_pm_channel.sv
// One pattern channel: masked window compare, IDLE/ARMED/FIRED state
// machine, sticky match flag, registered match pulse and saturating
// hit counter.
// Ports:
//   clk, rst_n       clock and internally synchronised active-low reset
//   i_arm            arm level; i_arm_rise / i_arm_fall its edges
//   i_capture_done   one cycle when the capture-in-progress level drops
//   i_oneshot        stop after the first match until re-armed
//   i_valid          a byte is being shifted in this cycle
//   i_window         window including the incoming byte (byte 0 newest)
//   i_pattern/i_mask this channel's pattern and compare mask
//   i_len            pattern length in bytes
//   i_fill           bytes shifted since arming, before this byte
//   o_hit            combinational match this cycle
//   o_pulse          o_hit delayed by one clock
//   o_sticky         match flag held until capture done or disarm
//   o_count          saturating match count
module pw_pm_channel
  import pw_multi_pattern_matcher_pkg::*;
#(
  parameter int pPATTERN_BYTES = 8,
  parameter int pCOUNT_WIDTH   = 16,
  parameter int pFILL_WIDTH    = 4
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                i_arm,
  input  logic                                i_arm_rise,
  input  logic                                i_arm_fall,
  input  logic                                i_capture_done,
  input  logic                                i_oneshot,
  input  logic                                i_valid,
  input  logic [pPATTERN_BYTES*PM_BYTE_W-1:0] i_window,
  input  logic [pPATTERN_BYTES*PM_BYTE_W-1:0] i_pattern,
  input  logic [pPATTERN_BYTES*PM_BYTE_W-1:0] i_mask,
  input  logic [PM_LEN_W-1:0]                 i_len,
  input  logic [pFILL_WIDTH-1:0]              i_fill,
  output logic                                o_hit,
  output logic                                o_pulse,
  output logic                                o_sticky,
  output logic [pCOUNT_WIDTH-1:0]             o_count
);

  pm_state_e                 r_state;
  pm_state_e                 w_state_next;
  logic [pPATTERN_BYTES-1:0] w_byte_ok;
  logic                      w_len_ok;
  logic                      w_fill_ok;
  logic                      w_compare;
  logic                      w_hit;
  logic                      r_pulse;
  logic                      r_sticky;
  logic [pCOUNT_WIDTH-1:0]   r_count;

  // Bytes beyond the programmed length are don't-care; within it only
  // the masked bits must agree with the pattern.
  for (genvar k = 0; k < pPATTERN_BYTES; k++) begin : g_byte
    assign w_byte_ok[k] = (k >= int'(i_len)) ||
      (((i_window[k*PM_BYTE_W +: PM_BYTE_W] ^ i_pattern[k*PM_BYTE_W +: PM_BYTE_W]) &
        i_mask[k*PM_BYTE_W +: PM_BYTE_W]) == '0);
  end

  // The incoming byte counts towards the fill, hence the +1, so that
  // bytes left over from before arming never take part in a match.
  assign w_len_ok  = lenEnabled(i_len, pPATTERN_BYTES);
  assign w_fill_ok = (int'(i_fill) + 1) >= int'(i_len);
  assign w_compare = i_valid & i_arm & w_len_ok & w_fill_ok & (&w_byte_ok);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= PM_IDLE;
    else        r_state <= w_state_next;
  end

  // Next state: disarming always returns to IDLE; a oneshot channel
  // parks in FIRED after its first match until it is disarmed.
  always_comb begin
    w_state_next = r_state;
    if (!i_arm) begin
      w_state_next = PM_IDLE;
    end else begin
      case (r_state)
        PM_IDLE:  w_state_next = (w_hit && i_oneshot) ? PM_FIRED : PM_ARMED;
        PM_ARMED: if (w_hit && i_oneshot) w_state_next = PM_FIRED;
        PM_FIRED: w_state_next = PM_FIRED;
        default:  w_state_next = PM_IDLE;
      endcase
    end
  end

  // Outputs of the state machine: a fired channel suppresses its matches
  always_comb begin
    w_hit = w_compare && (r_state != PM_FIRED);
  end

  // Pulse, sticky flag and counter; a new match beats a clear in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pulse  <= 1'b0;
      r_sticky <= 1'b0;
      r_count  <= '0;
    end else begin
      r_pulse <= w_hit;
      if (w_hit)                            r_sticky <= 1'b1;
      else if (i_capture_done || i_arm_fall) r_sticky <= 1'b0;
      if (i_arm_rise)                       r_count <= '0;
      else if (w_hit && !(&r_count))        r_count <= r_count + pCOUNT_WIDTH'(1);
    end
  end

  assign o_hit    = w_hit;
  assign o_pulse  = r_pulse;
  assign o_sticky = r_sticky;
  assign o_count  = r_count;

endmodule

// File: rtl/pw_multi_pattern_matcher.sv
// Multi-channel byte pattern matcher.
// Keeps a sliding window of the most recent valid bytes plus a count of
// bytes seen since arming, and hands both to pCHANNELS independent
// pattern channels. Channel results are merged into registered
// capture/trigger pulses and the lowest matching channel index.
// Ports:
//   fe_clk   sole clock
//   reset_n  asynchronous active-low reset, released synchronously
//   bus      slave side of pw_multi_pattern_matcher_if (config, data, results)
module pw_multi_pattern_matcher
  import pw_multi_pattern_matcher_pkg::*;
#(
  parameter int pCHANNELS      = 2,
  parameter int pPATTERN_BYTES = 8,
  parameter int pCOUNT_WIDTH   = 16
) (
  input  logic                      fe_clk,
  input  logic                      reset_n,
  pw_multi_pattern_matcher_if.slave bus
);

  localparam int lpWIN_W  = pPATTERN_BYTES * PM_BYTE_W;
  localparam int lpFILL_W = $clog2(pPATTERN_BYTES + 1);

  logic [1:0]                        r_rst_sync;
  logic                              w_rst_n;
  logic                              r_arm_d;
  logic                              r_capt_d;
  logic                              w_arm_rise;
  logic                              w_arm_fall;
  logic                              w_capture_done;
  logic [lpWIN_W-1:0]                r_window;
  logic [lpWIN_W-1:0]                w_window_next;
  logic [lpFILL_W-1:0]               r_fill;
  logic [pCHANNELS-1:0]              w_hit;
  logic [pCHANNELS-1:0]              w_pulse;
  logic [pCHANNELS-1:0]              w_sticky;
  logic [pCHANNELS*pCOUNT_WIDTH-1:0] w_count;
  logic                              w_any_capture;
  logic                              w_any_trigger;
  logic [PM_CHAN_IDX_W-1:0]          w_first;
  logic                              r_capture;
  logic                              r_trigger;
  logic [PM_CHAN_IDX_W-1:0]          r_channel;

  // Reset asserts immediately but releases only on a clock edge, so
  // every flop below leaves reset in the same cycle.
  always_ff @(posedge fe_clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  // Previous arm/capturing levels; reset to 0 so a held-high arm is seen
  // as a fresh rising edge on the first clock after reset.
  always_ff @(posedge fe_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_arm_d  <= 1'b0;
      r_capt_d <= 1'b0;
    end else begin
      r_arm_d  <= bus.I_arm;
      r_capt_d <= bus.I_capturing;
    end
  end

  assign w_arm_rise     = bus.I_arm & ~r_arm_d;
  assign w_arm_fall     = ~bus.I_arm & r_arm_d;
  assign w_capture_done = ~bus.I_capturing & r_capt_d;

  // Channels compare against the window as it will look once the
  // incoming byte is shifted in, so a match is decided on its own byte.
  if (pPATTERN_BYTES == 1) begin : g_win_single
    assign w_window_next = bus.I_fe_data;
  end else begin : g_win_multi
    assign w_window_next = {r_window[lpWIN_W-PM_BYTE_W-1:0], bus.I_fe_data};
  end

  // Window and fill counter advance only on valid bytes; the fill
  // restarts from zero whenever arming begins.
  always_ff @(posedge fe_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_window <= '0;
      r_fill   <= '0;
    end else begin
      if (bus.I_fe_data_valid) r_window <= w_window_next;
      if (w_arm_rise) begin
        r_fill <= '0;
      end else if (bus.I_fe_data_valid && (r_fill != lpFILL_W'(pPATTERN_BYTES))) begin
        r_fill <= r_fill + lpFILL_W'(1);
      end
    end
  end

  for (genvar ch = 0; ch < pCHANNELS; ch++) begin : g_channel
    pw_pm_channel #(
      .pPATTERN_BYTES (pPATTERN_BYTES),
      .pCOUNT_WIDTH   (pCOUNT_WIDTH),
      .pFILL_WIDTH    (lpFILL_W)
    ) u_channel (
      .clk            (fe_clk),
      .rst_n          (w_rst_n),
      .i_arm          (bus.I_arm),
      .i_arm_rise     (w_arm_rise),
      .i_arm_fall     (w_arm_fall),
      .i_capture_done (w_capture_done),
      .i_oneshot      (bus.I_oneshot),
      .i_valid        (bus.I_fe_data_valid),
      .i_window       (w_window_next),
      .i_pattern      (bus.I_pattern[ch*lpWIN_W +: lpWIN_W]),
      .i_mask         (bus.I_mask[ch*lpWIN_W +: lpWIN_W]),
      .i_len          (bus.I_pattern_bytes[ch*PM_LEN_W +: PM_LEN_W]),
      .i_fill         (r_fill),
      .o_hit          (w_hit[ch]),
      .o_pulse        (w_pulse[ch]),
      .o_sticky       (w_sticky[ch]),
      .o_count        (w_count[ch*pCOUNT_WIDTH +: pCOUNT_WIDTH])
    );
  end

  // Merge this cycle's matches; scanning downwards leaves the lowest
  // matching index in w_first.
  always_comb begin
    w_any_capture = 1'b0;
    w_any_trigger = 1'b0;
    w_first       = '0;
    for (int ch = pCHANNELS - 1; ch >= 0; ch--) begin
      if (w_hit[ch]) begin
        w_first = PM_CHAN_IDX_W'(ch);
        if (bus.I_action[ch*PM_ACTION_W +: PM_ACTION_W] == PM_CAPTURE) w_any_capture = 1'b1;
        if (bus.I_action[ch*PM_ACTION_W +: PM_ACTION_W] == PM_TRIGGER) w_any_trigger = 1'b1;
      end
    end
  end

  // Registered alongside the channel pulses so all results line up
  always_ff @(posedge fe_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_capture <= 1'b0;
      r_trigger <= 1'b0;
      r_channel <= '0;
    end else begin
      r_capture <= w_any_capture;
      r_trigger <= w_any_trigger;
      r_channel <= w_first;
    end
  end

  assign bus.O_match         = w_sticky;
  assign bus.O_match_pulse   = w_pulse;
  assign bus.O_match_channel = r_channel;
  assign bus.O_match_capture = r_capture;
  assign bus.O_match_trigger = r_trigger;
  assign bus.O_hit_count     = w_count;

endmodule

// File: tb/tb_pw_multi_pattern_matcher.sv
// Self-checking bench for pw_multi_pattern_matcher: directed scenarios
// followed by randomized traffic, every cycle compared against a
// byte-history reference model.
module tb_pw_multi_pattern_matcher;
  import pw_multi_pattern_matcher_pkg::*;

  localparam int CH      = 3;
  localparam int NB      = 4;
  localparam int CW      = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic fe_clk;
  logic reset_n;
  int   checks;
  int   failures;
  logic arm;
  logic oneshot;
  logic capturing;

  // Channel configuration as the bench sees it
  logic [7:0] cfgPat  [CH][NB];
  logic [7:0] cfgMask [CH][NB];
  logic [7:0] cfgLen  [CH];
  logic [1:0] cfgAct  [CH];

  // Reference model state: recent bytes (newest first), bytes since arming,
  // per-channel fired/sticky/count, previous control levels
  logic [7:0]    mWin [NB];
  int            mSince;
  bit            mFired   [CH];
  bit            mSticky  [CH];
  int            mCount   [CH];
  bit            mArmPrev;
  bit            mCaptPrev;
  logic [CH-1:0] expPulse;
  logic          expCap;
  logic          expTrig;
  int            expChan;

  pw_multi_pattern_matcher_if #(.pCHANNELS(CH), .pPATTERN_BYTES(NB), .pCOUNT_WIDTH(CW)) bus ();

  pw_multi_pattern_matcher #(.pCHANNELS(CH), .pPATTERN_BYTES(NB), .pCOUNT_WIDTH(CW)) dut (
    .fe_clk  (fe_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial fe_clk = 1'b0;
  always #5 fe_clk = ~fe_clk;

  task automatic modelReset();
    for (int k = 0; k < NB; k++) mWin[k] = 8'h00;
    mSince = 0;
    for (int ch = 0; ch < CH; ch++) begin
      mFired[ch]  = 1'b0;
      mSticky[ch] = 1'b0;
      mCount[ch]  = 0;
    end
    mArmPrev  = 1'b0;
    mCaptPrev = 1'b0;
    expPulse  = '0;
    expCap    = 1'b0;
    expTrig   = 1'b0;
    expChan   = 0;
  endtask

  // pat/mask hold byte 0 (newest) in the low byte
  task automatic setChannel(input int ch, input int len, input logic [1:0] act,
                            input logic [NB*8-1:0] pat, input logic [NB*8-1:0] mask);
    cfgLen[ch] = 8'(len);
    cfgAct[ch] = act;
    for (int k = 0; k < NB; k++) begin
      cfgPat[ch][k]  = pat[k*8 +: 8];
      cfgMask[ch][k] = mask[k*8 +: 8];
    end
  endtask

  task automatic disableAll();
    for (int ch = 0; ch < CH; ch++) setChannel(ch, 0, PM_NOP, '0, '1);
  endtask

  task automatic driveConfig();
    for (int ch = 0; ch < CH; ch++) begin
      bus.I_pattern_bytes[ch*8 +: 8] = cfgLen[ch];
      bus.I_action[ch*2 +: 2]        = cfgAct[ch];
      for (int k = 0; k < NB; k++) begin
        bus.I_pattern[(ch*NB+k)*8 +: 8] = cfgPat[ch][k];
        bus.I_mask[(ch*NB+k)*8 +: 8]    = cfgMask[ch][k];
      end
    end
  endtask

  // Applies one cycle of the behavioural rules to the model and sets the
  // outputs expected right after the coming clock edge.
  task automatic modelStep(input logic [7:0] data, input bit valid);
    bit         armRise, armFall, captFall, hit, found;
    logic [7:0] cand [NB];
    int         len;
    armRise  = arm && !mArmPrev;
    armFall  = !arm && mArmPrev;
    captFall = !capturing && mCaptPrev;
    cand[0]  = data;
    for (int k = 1; k < NB; k++) cand[k] = mWin[k-1];
    expPulse = '0;
    expCap   = 1'b0;
    expTrig  = 1'b0;
    expChan  = 0;
    found    = 1'b0;
    for (int ch = 0; ch < CH; ch++) begin
      len = int'(cfgLen[ch]);
      hit = valid && arm && !mFired[ch] && (len >= 1) && (len <= NB) && (mSince + 1 >= len);
      for (int k = 0; k < len && k < NB; k++)
        if (((cand[k] ^ cfgPat[ch][k]) & cfgMask[ch][k]) != 8'h00) hit = 1'b0;
      if (hit) begin
        expPulse[ch] = 1'b1;
        if (!found) begin
          expChan = ch;
          found   = 1'b1;
        end
        if (cfgAct[ch] == PM_CAPTURE) expCap  = 1'b1;
        if (cfgAct[ch] == PM_TRIGGER) expTrig = 1'b1;
      end
      if (hit)                      mSticky[ch] = 1'b1;
      else if (captFall || armFall) mSticky[ch] = 1'b0;
      if (armRise)                       mCount[ch] = 0;
      else if (hit && mCount[ch] < CNT_MAX) mCount[ch] = mCount[ch] + 1;
      if (!arm)                 mFired[ch] = 1'b0;
      else if (hit && oneshot)  mFired[ch] = 1'b1;
    end
    if (armRise)                    mSince = 0;
    else if (valid && mSince < NB)  mSince = mSince + 1;
    if (valid) begin
      for (int k = NB - 1; k > 0; k--) mWin[k] = mWin[k-1];
      mWin[0] = data;
    end
    mArmPrev  = arm;
    mCaptPrev = capturing;
  endtask

  task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    logic [CH-1:0] expSticky;
    for (int ch = 0; ch < CH; ch++) expSticky[ch] = mSticky[ch];
    checkValue({tag, "_pulse"},   32'(bus.O_match_pulse),   32'(expPulse));
    checkValue({tag, "_match"},   32'(bus.O_match),         32'(expSticky));
    checkValue({tag, "_capture"}, 32'(bus.O_match_capture), 32'(expCap));
    checkValue({tag, "_trigger"}, 32'(bus.O_match_trigger), 32'(expTrig));
    checkValue({tag, "_channel"}, 32'(bus.O_match_channel), 32'(expChan));
    for (int ch = 0; ch < CH; ch++)
      checkValue($sformatf("%s_count%0d", tag, ch), 32'(bus.O_hit_count[ch*CW +: CW]), 32'(mCount[ch]));
  endtask

  task automatic applyStimulus(input logic [7:0] data, input bit valid, input string tag);
    bus.I_arm           = arm;
    bus.I_oneshot       = oneshot;
    bus.I_capturing     = capturing;
    bus.I_fe_data       = data;
    bus.I_fe_data_valid = valid;
    driveConfig();
    modelStep(data, valid);
    @(posedge fe_clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(8'h00, 1'b0, tag);
  endtask

  task automatic doReset(input string tag);
    arm       = 1'b0;
    capturing = 1'b0;
    reset_n   = 1'b0;
    bus.I_arm           = 1'b0;
    bus.I_capturing     = 1'b0;
    bus.I_fe_data_valid = 1'b0;
    #2;
    modelReset();
    checkOutput({tag, "_inreset"});
    @(posedge fe_clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) idle({tag, "_release"});
  endtask

  logic [7:0] alpha [3];
  int         pulseSum;
  int         firstPulse;

  initial begin
    checks    = 0;
    failures  = 0;
    oneshot   = 1'b0;
    bus.I_oneshot = 1'b0;
    bus.I_fe_data = 8'h00;
    alpha[0]  = 8'hA0;
    alpha[1]  = 8'hA1;
    alpha[2]  = 8'hB1;
    disableAll();
    driveConfig();
    doReset("por");

    // Repeated-prefix pattern AA AB in stream AA AA AB
    setChannel(0, 2, PM_NOP, 32'h0000_AAAB, '1);
    arm = 1'b1;
    idle("r20_arm");
    applyStimulus(8'hAA, 1'b1, "r20_b0");
    applyStimulus(8'hAA, 1'b1, "r20_b1");
    applyStimulus(8'hAB, 1'b1, "r20_b2");
    checkValue("r20_pulse0", 32'(bus.O_match_pulse[0]), 32'd1);
    checkValue("r20_count0", 32'(bus.O_hit_count[0 +: CW]), 32'd1);

    // Fill guard: window already holds 11 22 33 but only two bytes since arming
    arm = 1'b0;
    idle("r21_disarm");
    setChannel(0, 3, PM_NOP, 32'h0011_2233, '1);
    applyStimulus(8'h11, 1'b1, "r21_pre");
    arm = 1'b1;
    idle("r21_arm");
    applyStimulus(8'h22, 1'b1, "r21_a");
    applyStimulus(8'h33, 1'b1, "r21_b");
    checkValue("r21_guard", 32'(bus.O_match_pulse[0]), 32'd0);
    applyStimulus(8'h11, 1'b1, "r21_c");
    applyStimulus(8'h22, 1'b1, "r21_d");
    applyStimulus(8'h33, 1'b1, "r21_e");
    checkValue("r21_match", 32'(bus.O_match_pulse[0]), 32'd1);

    // Oneshot: three matching bytes yield one pulse until re-armed
    arm = 1'b0;
    idle("r22_disarm");
    oneshot = 1'b1;
    setChannel(0, 1, PM_NOP, 32'h55, '1);
    arm = 1'b1;
    idle("r22_arm");
    pulseSum = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(8'h55, 1'b1, "r22_burst");
      pulseSum += int'(bus.O_match_pulse[0]);
    end
    checkValue("r22_onepulse", 32'(pulseSum), 32'd1);
    arm = 1'b0;
    idle("r22_off");
    arm = 1'b1;
    idle("r22_rearm");
    applyStimulus(8'h55, 1'b1, "r22_again");
    checkValue("r22_pulse2", 32'(bus.O_match_pulse[0]), 32'd1);
    checkValue("r22_count", 32'(bus.O_hit_count[0 +: CW]), 32'd1);

    // Capture and trigger from two channels on the same byte
    arm = 1'b0;
    oneshot = 1'b0;
    idle("r23_disarm");
    setChannel(0, 1, PM_CAPTURE, 32'h7E, '1);
    setChannel(1, 1, PM_TRIGGER, 32'h7E, '1);
    arm = 1'b1;
    idle("r23_arm");
    applyStimulus(8'h7E, 1'b1, "r23_hit");
    checkValue("r23_capture", 32'(bus.O_match_capture), 32'd1);
    checkValue("r23_trigger", 32'(bus.O_match_trigger), 32'd1);
    checkValue("r23_channel", 32'(bus.O_match_channel), 32'd0);
    checkValue("r23_pulses", 32'(bus.O_match_pulse), 32'b011);

    // Masked compare and sticky clear when capturing ends
    arm = 1'b0;
    idle("r24_disarm");
    disableAll();
    setChannel(0, 1, PM_NOP, 32'hA5, 32'hF0);
    arm = 1'b1;
    capturing = 1'b1;
    idle("r24_arm");
    applyStimulus(8'hAF, 1'b1, "r24_hit");
    checkValue("r24_sticky_set", 32'(bus.O_match[0]), 32'd1);
    idle("r24_hold");
    capturing = 1'b0;
    idle("r24_captdone");
    checkValue("r24_sticky_clr", 32'(bus.O_match[0]), 32'd0);

    // Length boundaries and counter saturation with mask 0 (matches anything)
    arm = 1'b0;
    idle("bnd_disarm");
    setChannel(0, 1,      PM_NOP, '0, '0);
    setChannel(1, NB + 1, PM_NOP, '0, '0);
    setChannel(2, NB,     PM_NOP, '0, '0);
    arm = 1'b1;
    idle("bnd_arm");
    pulseSum   = 0;
    firstPulse = -1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(8'(i), 1'b1, "bnd_stream");
      pulseSum += int'(bus.O_match_pulse[1]);
      if (firstPulse < 0 && bus.O_match_pulse[2]) firstPulse = i;
    end
    checkValue("bnd_len_over", 32'(pulseSum), 32'd0);
    checkValue("bnd_len_full", 32'(firstPulse), 32'(NB - 1));
    checkValue("bnd_saturate", 32'(bus.O_hit_count[0 +: CW]), 32'(CNT_MAX));

    // Reset in the middle of a partial pattern
    arm = 1'b0;
    idle("r25_disarm");
    disableAll();
    setChannel(0, 3, PM_NOP, 32'h0011_2233, '1);
    arm = 1'b1;
    idle("r25_arm");
    applyStimulus(8'h11, 1'b1, "r25_a");
    applyStimulus(8'h22, 1'b1, "r25_b");
    doReset("r25");
    arm = 1'b1;
    idle("r25_rearm");
    applyStimulus(8'h33, 1'b1, "r25_c");
    checkValue("r25_nopulse", 32'(bus.O_match_pulse[0]), 32'd0);
    checkValue("r25_count", 32'(bus.O_hit_count), 32'd0);

    // Randomized traffic with live reconfiguration
    for (int ch = 0; ch < CH; ch++)
      setChannel(ch, $urandom_range(1, NB), 2'($urandom_range(0, 2)),
                 {alpha[$urandom_range(0, 2)], alpha[$urandom_range(0, 2)],
                  alpha[$urandom_range(0, 2)], alpha[$urandom_range(0, 2)]}, '1);
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit         doValid;
      int         ch;
      logic [31:0] mk;
      if ($urandom_range(0, 19) == 0) arm = !arm;
      if (!arm && $urandom_range(0, 3) == 0) oneshot = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) capturing = !capturing;
      if ($urandom_range(0, 24) == 0) begin
        ch = $urandom_range(0, CH - 1);
        case ($urandom_range(0, 5))
          0:       mk = 32'hF0F0_F0F0;
          1:       mk = 32'h0F0F_0F0F;
          2:       mk = 32'h0000_0000;
          default: mk = 32'hFFFF_FFFF;
        endcase
        setChannel(ch, $urandom_range(0, NB + 1), 2'($urandom_range(0, 2)),
                   {alpha[$urandom_range(0, 2)], alpha[$urandom_range(0, 2)],
                    alpha[$urandom_range(0, 2)], alpha[$urandom_range(0, 2)]}, mk);
      end
      doValid = ($urandom_range(0, 9) < 7) && !(arm && !bus.I_arm);
      applyStimulus(alpha[$urandom_range(0, 2)], doValid, "rnd");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pw_multi_pattern_matcher.md
PW_MULTI_PATTERN_MATCHER -- requirements
Module: pw_multi_pattern_matcher

Interface
REQ-001 The block SHALL have parameter pCHANNELS, default 2: number of independent pattern channels (1..8).
REQ-002 The block SHALL have parameter pPATTERN_BYTES, default 8: maximum pattern length in bytes (1..64).
REQ-003 The block SHALL have parameter pCOUNT_WIDTH, default 16: width of each per-channel hit counter.
REQ-004 Ports SHALL be:
- fe_clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- I_arm  in  1  level; matching enabled while high.
- I_oneshot  in  1  1 = a channel stops after its first match until re-armed; 0 = continuous.
- I_pattern  in  pCHANNELS*pPATTERN_BYTES*8  per-channel pattern; byte 0 = most recent byte.
- I_mask  in  pCHANNELS*pPATTERN_BYTES*8  per-channel bit mask; 1 = compare.
- I_pattern_bytes  in  pCHANNELS*8  per-channel length.
- I_action  in  pCHANNELS*2  per-channel action: NOP, CAPTURE or TRIGGER.
- I_fe_data  in  8  input byte.
- I_fe_data_valid  in  1  byte strobe.
- I_capturing  in  1  capture-in-progress level.
- O_match  out  pCHANNELS  sticky per-channel match flag.
- O_match_pulse  out  pCHANNELS  one-cycle pulse per match event.
- O_match_channel  out  3  lowest-index channel in the current pulse.
- O_match_capture  out  1  pulse; any pulsing channel has action CAPTURE.
- O_match_trigger  out  1  pulse; any pulsing channel has action TRIGGER.
- O_hit_count  out  pCHANNELS*pCOUNT_WIDTH  per-channel saturating match count.

Function
REQ-005 The block SHALL hold a shift register of the last pPATTERN_BYTES valid bytes; it shifts only when I_fe_data_valid=1.
REQ-006 The block SHALL hold a fill counter (0..pPATTERN_BYTES, saturating) of bytes shifted since arming; it clears to 0 on the cycle I_arm rises.
REQ-007 A channel SHALL match when all of the following hold on a cycle with I_fe_data_valid=1 and I_arm=1:
- (window & mask) equals (pattern & mask) over its newest L bytes, where L = that channel's I_pattern_bytes;
- fill counter + 1 >= L;
- the channel is not in state FIRED.
REQ-008 Matching SHALL be window-based, so overlapping occurrences and patterns with repeated prefixes are all detected (pattern AA AB in stream AA AA AB matches).
REQ-009 L=0 or L>pPATTERN_BYTES SHALL disable the channel; it never matches.
REQ-010 O_match_pulse SHALL assert exactly one fe_clk cycle after the matching byte's valid cycle. O_match_capture, O_match_trigger and O_match_channel SHALL be registered and aligned with it.
REQ-011 Each channel SHALL have a state machine:
- IDLE -> ARMED when I_arm=1.
- ARMED -> FIRED on a match when I_oneshot=1.
- ARMED stays ARMED on a match when I_oneshot=0.
- Any state -> IDLE when I_arm=0.
REQ-012 O_match[n] SHALL set on a channel-n match. It SHALL clear on the cycle after I_capturing falls (capture done) or when I_arm falls. If set and clear occur on the same cycle, set SHALL win.
REQ-013 O_hit_count[n] SHALL increment on each channel-n match and saturate at all-ones. It SHALL clear when I_arm rises.
REQ-014 Simultaneous matches on several channels SHALL all pulse. O_match_channel SHALL report the lowest index.
REQ-015 Changes to pattern, mask or length while armed SHALL take effect on the next valid byte; no re-arm is required.

Reset
REQ-016 While reset_n=0, all outputs, counters, the window and the flags SHALL be 0, and every channel SHALL be in IDLE, with asynchronous assertion.
REQ-017 Reset deassertion SHALL be synchronised internally to fe_clk. The first clock after release SHALL behave as unarmed.

Structure
REQ-018 Action encodings (PM_NOP=0, PM_CAPTURE=1, PM_TRIGGER=2) and the channel state encodings SHALL reside in the shared defines package used by the register block.
REQ-019 The per-channel compare, state machine and counter SHALL be one sub-module, pw_pm_channel, instantiated pCHANNELS times by generate. The window and fill counter SHALL stay in the top level.

Verification
REQ-020 Ch0 pattern AA AB, L=2, full mask, continuous mode; stream AA AA AB -> one O_match_pulse[0] one cycle after AB; hit_count=1.
REQ-021 Ch0 L=3 pattern 11 22 33; arm; send 22 33 only -> no match (fill guard). Then send 11 22 33 -> match.
REQ-022 Oneshot=1, pattern 55, L=1; send 55 55 55 -> exactly one pulse, state FIRED. Toggle I_arm 0->1, send 55 -> a second pulse; hit_count=1.
REQ-023 Ch0 action CAPTURE, ch1 action TRIGGER, both pattern 7E; send 7E -> O_match_capture=1, O_match_trigger=1, O_match_channel=0 on the same cycle.
REQ-024 Mask 0xF0, pattern 0xA5, L=1; send 0xAF -> match. Then drop I_capturing 1->0 -> O_match cleared.
REQ-025 Assert reset_n=0 mid-pattern, then release -> no pulse from the prior partial window; all counts 0.
